// File: rtl/aes_pkg.sv
// Shared AES types, the FIPS-197 forward S-box and the [r][c] byte-position helpers.
// Byte [r][c] sits at bits 8*(4r+c)+7 : 8*(4r+c); [3][3] is the MSB byte (AES row 0, column 0).
package aes_pkg;

  typedef logic [7:0] byte_t;
  typedef byte_t [15:0] state_t;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic int unsigned byte_idx(input int unsigned r, input int unsigned c);
    return 4 * r + c;
  endfunction

  function automatic int unsigned bit_off(input int unsigned r, input int unsigned c);
    return 8 * byte_idx(r, c);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte forward AES S-box lookup, purely combinational.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_first_round.sv
// One AES round without MixColumns: AddRoundKey(ShiftRows(SubBytes(roundin)), key),
// followed by a single output register stage with a valid flag.
module aes_first_round
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [127:0] roundin,
  input  logic [127:0] key,
  output logic         out_valid,
  output logic [127:0] roundout
);

  state_t sb;
  state_t sr;
  state_t res;

  logic [127:0] roundout_d, roundout_q;
  logic         out_valid_d, out_valid_q;

  // Index r=3 is AES row 0, so row r rotates by (3-r): source column is (c+r+1) mod 4.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      aes_sbox u_sbox (
        .in_byte  (roundin[bit_off(r, c) +: 8]),
        .out_byte (sb[byte_idx(r, c)])
      );
      assign sr[byte_idx(r, c)]  = sb[byte_idx(r, (c + r + 1) % 4)];
      assign res[byte_idx(r, c)] = sr[byte_idx(r, c)] ^ key[bit_off(r, c) +: 8];
    end
  end

  always_comb begin
    out_valid_d = in_valid;
    roundout_d  = roundout_q;
    if (in_valid) begin
      roundout_d = res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      roundout_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      roundout_q  <= roundout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign roundout  = roundout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_aes_first_round.sv
// Self-checking bench for aes_first_round: known-answer table, hand sequences and
// randomized traffic against a GF(2^8)-based reference model.
module tb_aes_first_round;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] roundin = '0;
  logic [127:0] key = '0;
  logic         out_valid;
  logic [127:0] roundout;

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  logic [7:0] sbox_m [256];

  aes_first_round dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .roundin   (roundin),
    .key       (key),
    .out_valid (out_valid),
    .roundout  (roundout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse (x^254) then the affine map.
  function automatic logic [7:0] sbox_def(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] k);
    logic [127:0] o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        int src = (c - (3 - r) + 4) % 4;
        o[8*(4*r+c) +: 8] = sbox_m[st[8*(4*r+src) +: 8]] ^ k[8*(4*r+c) +: 8];
      end
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string        name;
    logic [127:0] rin;
    logic [127:0] k;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] REF_IN  = 128'hcc3eff3b_a16759af_048502aa_a1005f34;
  localparam logic [127:0] REF_KEY = 128'hb48ef352_ba98134e_7f4d5920_86261876;
  localparam logic [127:0] REF_OUT = 128'hff3ce5b0_3f536a7c_08e1abb7_9e147bb9;
  localparam logic [127:0] ALL63   = {16{8'h63}};

  vec_t vecs [3];

  initial begin
    logic [127:0] exp_out;
    logic         exp_valid;
    logic [127:0] held;

    for (int i = 0; i < 256; i++) sbox_m[i] = sbox_def(8'(i));

    vecs[0] = '{"ref_vector", REF_IN, REF_KEY, REF_OUT};
    vecs[1] = '{"zero_zero", '0, '0, ALL63};
    vecs[2] = '{"zero_iota", '0, 128'h00010203_04050607_08090a0b_0c0d0e0f,
                128'h63626160_67666564_6b6a6968_6f6e6d6c};

    #12;
    check("reset_roundout", roundout, '0);
    check("reset_out_valid", {127'b0, out_valid}, 128'd1 - 128'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Known-answer table, each beat followed by an idle cycle that must hold the result.
    for (int v = 0; v < 3; v++) begin
      in_valid = 1'b1;
      roundin  = vecs[v].rin;
      key      = vecs[v].k;
      cycle();
      check({vecs[v].name, "_out"}, roundout, vecs[v].exp);
      check({vecs[v].name, "_valid"}, {127'b0, out_valid}, 128'd1);
      in_valid = 1'b0;
      roundin  = 'x;
      key      = 'x;
      cycle();
      check({vecs[v].name, "_idle_valid"}, {127'b0, out_valid}, 128'd0);
      check({vecs[v].name, "_idle_hold"}, roundout, vecs[v].exp);
    end

    check("ref_byte_3_3", {120'b0, REF_OUT[127:120]}, {120'b0, 8'hff});

    // Back-to-back beats, then an idle cycle.
    in_valid = 1'b1; roundin = '0; key = '0;
    cycle();
    check("b2b_first_out", roundout, ALL63);
    check("b2b_first_valid", {127'b0, out_valid}, 128'd1);
    roundin = REF_IN; key = REF_KEY;
    cycle();
    check("b2b_second_out", roundout, REF_OUT);
    check("b2b_second_valid", {127'b0, out_valid}, 128'd1);
    in_valid = 1'b0; roundin = '0; key = '0;
    cycle();
    check("b2b_idle_valid", {127'b0, out_valid}, 128'd0);
    check("b2b_idle_hold", roundout, REF_OUT);

    // Asynchronous reset landing between clock edges.
    in_valid = 1'b1; roundin = '0; key = '0;
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_roundout", roundout, '0);
    check("async_rst_valid", {127'b0, out_valid}, 128'd0);
    cycle();
    check("in_rst_roundout", roundout, '0);
    check("in_rst_valid", {127'b0, out_valid}, 128'd0);
    #2 rst_n = 1'b1;
    in_valid = 1'b0;
    cycle();
    check("post_rst_idle_roundout", roundout, '0);
    check("post_rst_idle_valid", {127'b0, out_valid}, 128'd0);
    in_valid = 1'b1;
    cycle();
    check("post_rst_capture", roundout, ALL63);
    check("post_rst_capture_valid", {127'b0, out_valid}, 128'd1);

    // Randomized traffic with gaps.
    exp_out   = ALL63;
    exp_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      roundin  = {$urandom, $urandom, $urandom, $urandom};
      key      = {$urandom, $urandom, $urandom, $urandom};
      held     = exp_out;
      if (in_valid) exp_out = ref_round(roundin, key);
      else          exp_out = held;
      exp_valid = in_valid;
      cycle();
      check("rand_out", roundout, exp_out);
      check("rand_valid", {127'b0, out_valid}, {127'b0, exp_valid});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
